// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen
//
// A bank of N_CH rate dividers that all run on the single system clock.
// Every channel produces a one-cycle tick strobe, meant to be used as a
// clock enable, and a registered square-wave level. Downstream logic stays
// on clk_i and gates on tick_o, so no divided clocks are created.
// When CASCADE is set, channel k>0 counts ticks of channel k-1.
//
// Ports:
//   clk_i      system clock; all state changes on the rising edge
//   rst_i      asynchronous active-high reset; reloads DIV_INIT
//   en_i       global advance enable; low freezes counts and suppresses ticks
//   clr_i      synchronous clear of every counter
//   cfg_we_i   divisor write strobe
//   cfg_ch_i   channel targeted by the write
//   cfg_div_i  new divisor; zero is rejected
//   cfg_err_o  one-cycle pulse after a rejected write
//   tick_o     one-cycle rate strobes, one bit per channel
//   sq_o       square-wave levels, one bit per channel

module multi_rate_tick_gen #(
    parameter int                     N_CH     = 2,
    parameter int                     CNT_W    = 32,
    parameter bit                     CASCADE  = 1'b1,
    parameter logic [N_CH*CNT_W-1:0]  DIV_INIT = {32'd1000, 32'd100000},
    localparam int                    CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             cfg_err_o,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  sq_o
);

    // One extra bit so the channel count itself can be compared against
    // cfg_ch_i without overflowing when N_CH is a power of two.
    localparam logic [CH_W:0] N_CH_EXT = (CH_W+1)'(N_CH);

    logic [CNT_W-1:0] div_q [N_CH];
    logic [CNT_W-1:0] div_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  sq_q, sq_d;
    logic             cfg_err_q, cfg_err_d;
    logic [N_CH-1:0]  adv;
    logic [N_CH-1:0]  wr_hit;
    logic             wr_acc;

    // Reset divisor for channel k; a zero slice would never terminate,
    // so it is promoted to 1 (tick on every advance).
    function automatic logic [CNT_W-1:0] init_div(input int k);
        logic [CNT_W-1:0] v;
        v = DIV_INIT[k*CNT_W +: CNT_W];
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Write qualification: the channel must exist and the divisor must be
    // nonzero. Anything else is dropped and flagged on cfg_err_o.
    always_comb begin
        wr_acc    = cfg_we_i && ({1'b0, cfg_ch_i} < N_CH_EXT) && (cfg_div_i != '0);
        cfg_err_d = cfg_we_i && !wr_acc;
        wr_hit    = '0;
        for (int k = 0; k < N_CH; k++) begin
            wr_hit[k] = wr_acc && (cfg_ch_i == CH_W'(k));
        end
    end

    // Advance events. Cascaded channels look at the registered tick of the
    // previous stage, which is why each stage lags by one cycle. A tick
    // arriving while en_i is low is simply lost.
    always_comb begin
        adv    = '0;
        adv[0] = en_i;
        for (int k = 1; k < N_CH; k++) begin
            adv[k] = CASCADE ? (en_i && tick_q[k-1]) : en_i;
        end
    end

    // Per-channel next state. Priority is clear, then accepted write, then
    // advance; the write path therefore swallows a same-cycle terminal count.
    // The divisor itself is still updated by a write that coincides with clr.
    // sq is recomputed only when the count is written, from the new count
    // and the divisor that governs it from now on.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            div_d[k]  = div_q[k];
            cnt_d[k]  = cnt_q[k];
            tick_d[k] = 1'b0;
            sq_d[k]   = sq_q[k];

            if (wr_hit[k]) begin
                div_d[k] = cfg_div_i;
            end

            if (clr_i) begin
                cnt_d[k] = '0;
                sq_d[k]  = ((div_d[k] >> 1) != '0);
            end else if (wr_hit[k]) begin
                cnt_d[k] = '0;
                sq_d[k]  = ((cfg_div_i >> 1) != '0);
            end else if (adv[k]) begin
                if (cnt_q[k] == div_q[k] - CNT_W'(1)) begin
                    cnt_d[k]  = '0;
                    tick_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
                sq_d[k] = (cnt_d[k] < (div_q[k] >> 1));
            end
        end
    end

    // State registers. Reset is asynchronous so outputs drop immediately
    // and counting restarts from zero with the parameter divisors.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_CH; k++) begin
                div_q[k] <= init_div(k);
                cnt_q[k] <= '0;
            end
            tick_q    <= '0;
            sq_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                div_q[k] <= div_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            tick_q    <= tick_d;
            sq_q      <= sq_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign tick_o    = tick_q;
    assign sq_o      = sq_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Testbench for multi_rate_tick_gen: directed scenarios with hand-computed
// expected tick, sq and cfg_err values. A second, three-channel instance is
// used where an out-of-range channel number must be representable.

module tb_multi_rate_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       cfgWe;
    logic [0:0] cfgCh;
    logic [7:0] cfgDiv;
    logic       cfgErr;
    logic [1:0] tick;
    logic [1:0] sq;

    logic       cfgWe3;
    logic [1:0] cfgCh3;
    logic [7:0] cfgDiv3;
    logic       cfgErr3;
    logic [2:0] tick3;
    logic [2:0] sq3;

    int checkCount = 0;
    int errCount   = 0;

    // 10 ns system clock
    always #5 clk = ~clk;

    multi_rate_tick_gen #(
        .N_CH(2), .CNT_W(8), .CASCADE(1'b1), .DIV_INIT({8'd3, 8'd4})
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .cfg_we_i(cfgWe), .cfg_ch_i(cfgCh), .cfg_div_i(cfgDiv),
        .cfg_err_o(cfgErr), .tick_o(tick), .sq_o(sq)
    );

    multi_rate_tick_gen #(
        .N_CH(3), .CNT_W(8), .CASCADE(1'b1), .DIV_INIT({8'd2, 8'd3, 8'd4})
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .cfg_we_i(cfgWe3), .cfg_ch_i(cfgCh3), .cfg_div_i(cfgDiv3),
        .cfg_err_o(cfgErr3), .tick_o(tick3), .sq_o(sq3)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the main instance inputs for the coming edge
    task automatic applyStimulus(input logic enV, input logic clrV, input logic weV,
                                 input logic [0:0] chV, input logic [7:0] divV);
        en     = enV;
        clr    = clrV;
        cfgWe  = weV;
        cfgCh  = chV;
        cfgDiv = divV;
    endtask

    // Advance one edge and move to the sampling point just after it
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges, check the reset state, then release
    // just after an edge so the next edge is edge 1.
    task automatic doReset(input string tag);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cfgWe3 = 1'b0; cfgCh3 = 2'd0; cfgDiv3 = 8'd0;
        stepEdge();
        stepEdge();
        checkOutput({tag, " rst tick"},   32'(tick),   32'd0);
        checkOutput({tag, " rst sq"},     32'(sq),     32'd0);
        checkOutput({tag, " rst cfgErr"}, 32'(cfgErr), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cfgWe3 = 1'b0; cfgCh3 = 2'd0; cfgDiv3 = 8'd0;

        // Scenario 1: free-running cadence and cascade
        doReset("s1");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int e = 1; e <= 25; e++) begin
            stepEdge();
            checkOutput($sformatf("s1 tick0 e%0d", e), 32'(tick[0]), 32'(e % 4 == 0));
            checkOutput($sformatf("s1 tick1 e%0d", e), 32'(tick[1]), 32'(e == 13 || e == 25));
            checkOutput($sformatf("s1 sq0 e%0d", e), 32'(sq[0]), 32'(e % 4 == 0 || e % 4 == 1));
            checkOutput($sformatf("s1 sq1 e%0d", e), 32'(sq[1]),
                        32'((e >= 13 && e <= 16) || e >= 25));
            checkOutput($sformatf("s1 cfgErr e%0d", e), 32'(cfgErr), 32'd0);
        end

        // Scenario 2: enable gap freezes the count
        doReset("s2");
        for (int e = 1; e <= 9; e++) begin
            applyStimulus((e <= 2 || e >= 8), 1'b0, 1'b0, 1'b0, 8'd0);
            stepEdge();
            checkOutput($sformatf("s2 tick0 e%0d", e), 32'(tick[0]), 32'(e == 9));
            checkOutput($sformatf("s2 sq0 e%0d", e), 32'(sq[0]), 32'(e == 1 || e == 9));
            checkOutput($sformatf("s2 tick1 e%0d", e), 32'(tick[1]), 32'd0);
        end

        // Scenario 3: divisor write on a terminal-count edge
        doReset("s3");
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
            else        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            stepEdge();
            checkOutput($sformatf("s3 tick0 e%0d", e), 32'(tick[0]), 32'(e >= 6 && e % 2 == 0));
            checkOutput($sformatf("s3 tick1 e%0d", e), 32'(tick[1]), 32'(e == 11));
            checkOutput($sformatf("s3 sq0 e%0d", e), 32'(sq[0]),
                        32'(e == 1 || (e >= 4 && e % 2 == 0)));
            checkOutput($sformatf("s3 cfgErr e%0d", e), 32'(cfgErr), 32'd0);
        end

        // Scenario 4: rejected writes (zero divisor, out-of-range channel)
        doReset("s4");
        for (int e = 1; e <= 13; e++) begin
            if (e == 2)      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
            else if (e == 5) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
            else             applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            cfgWe3  = (e == 7);
            cfgCh3  = 2'd3;
            cfgDiv3 = 8'd5;
            stepEdge();
            checkOutput($sformatf("s4 cfgErr e%0d", e), 32'(cfgErr), 32'(e == 2 || e == 5));
            checkOutput($sformatf("s4 cfgErr3 e%0d", e), 32'(cfgErr3), 32'(e == 7));
            checkOutput($sformatf("s4 tick0 e%0d", e), 32'(tick[0]), 32'(e % 4 == 0));
            checkOutput($sformatf("s4 tick1 e%0d", e), 32'(tick[1]), 32'(e == 13));
            checkOutput($sformatf("s4 tick3_0 e%0d", e), 32'(tick3[0]), 32'(e % 4 == 0));
        end
        cfgWe3 = 1'b0;

        // Scenario 5: clear on a terminal-count edge
        doReset("s5");
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1'b1, (e == 4), 1'b0, 1'b0, 8'd0);
            stepEdge();
            checkOutput($sformatf("s5 tick0 e%0d", e), 32'(tick[0]), 32'(e == 8));
            if (e == 4) checkOutput("s5 sq0 after clr", 32'(sq[0]), 32'd1);
        end

        // Scenario 6: asynchronous reset mid-count restores DIV_INIT
        doReset("s6");
        for (int e = 1; e <= 6; e++) begin
            if (e == 1)      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd5);
            else if (e == 6) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
            else             applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            stepEdge();
            checkOutput($sformatf("s6 tick0 e%0d", e), 32'(tick[0]), 32'(e == 6));
            checkOutput($sformatf("s6 cfgErr e%0d", e), 32'(cfgErr), 32'(e == 6));
        end
        checkOutput("s6 sq0 before rst", 32'(sq[0]), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("s6 async tick",   32'(tick),   32'd0);
        checkOutput("s6 async sq",     32'(sq),     32'd0);
        checkOutput("s6 async cfgErr", 32'(cfgErr), 32'd0);
        stepEdge();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            stepEdge();
            checkOutput($sformatf("s6 post tick0 e%0d", e), 32'(tick[0]), 32'(e % 4 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
